// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the data-memory load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_BAD = 2'b11;

    // True when byte lane `lane` of the word is touched by an access of this size at address offset `lo`.
    function automatic logic lane_en(input logic [1:0] size, input logic [1:0] lo, input logic [1:0] lane);
        unique case (size)
            SZ_B:    return lane == lo;
            SZ_H:    return lane[1] == lo[1];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        unique case (size)
            SZ_H:    return lo[0];
            SZ_W:    return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: extract+extend for loads, lane replacement for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int Data_W = 32
) (
    input  logic [Data_W-1:0] word_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [Data_W-1:0] wdata_i,
    output logic [Data_W-1:0] load_data_o,
    output logic [Data_W-1:0] merged_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte    = word_i[{addr_lo_i, 3'b000} +: 8];
        sel_half    = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        load_data_o = word_i;
        unique case (size_i)
            SZ_B:    load_data_o = {{24{~unsigned_i & sel_byte[7]}}, sel_byte};
            SZ_H:    load_data_o = {{16{~unsigned_i & sel_half[15]}}, sel_half};
            default: load_data_o = word_i;
        endcase
    end

    // Store data arrives right-aligned; each lane picks the wdata byte that lands on it.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] src;
            assign src = (size_i == SZ_B) ? wdata_i[7:0] :
                         (size_i == SZ_H) ? wdata_i[8*(gi%2) +: 8] :
                                            wdata_i[8*gi +: 8];
            assign merged_o[8*gi +: 8] = lane_en(size_i, addr_lo_i, 2'(gi)) ? src : word_i[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/dm_load_store_unit.sv
// Load/store unit in front of a word-only data memory; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_EN: reject misaligned H/W accesses with rsp_err instead of ignoring low bits.
module dm_load_store_unit
    import lsu_pkg::*;
#(
    parameter int Data_W = 32,
    parameter int Addr_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [Data_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [Data_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              dm_write_enable,
    output logic [31:0]       dm_addr,
    output logic [Data_W-1:0] dm_write_data,
    input  logic [Data_W-1:0] dm_read_data
);

    generate
        if (Data_W != 32 || Addr_W < 2 || (Addr_W & (Addr_W - 1)) != 0) begin : g_bad_param
            $error("dm_load_store_unit: Data_W must be 32 and Addr_W a power of two");
        end
    endgenerate

    lsu_state_e        state_q;
    logic              we_q;
    logic [2:0]        op_q;
    logic [1:0]        lo_q;
    logic [Data_W-1:0] wdata_q;
    logic              dm_we_q;
    logic [31:0]       dm_addr_q;
    logic [Data_W-1:0] dm_wdata_q;
    logic              rsp_valid_q;
    logic [Data_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              req_bad;
    logic [Data_W-1:0] load_data;
    logic [Data_W-1:0] merged_word;

    always_comb begin
        req_bad = (req_op[1:0] == SZ_BAD);
`ifdef LSU_MISALIGN_EN
        req_bad = req_bad | misaligned(req_op[1:0], req_addr[1:0]);
`endif
    end

    lsu_lane_align #(.Data_W(Data_W)) u_align (
        .word_i      (dm_read_data),
        .addr_lo_i   (lo_q),
        .size_i      (op_q[1:0]),
        .unsigned_i  (op_q[2]),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            op_q        <= 3'b000;
            lo_q        <= 2'b00;
            wdata_q     <= '0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        op_q    <= req_op;
                        lo_q    <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (req_bad) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            dm_addr_q <= {req_addr[31:2], 2'b00};
                            // Full-word stores need no read, so the write strobe goes out during ACCESS.
                            if (req_we && req_op[1:0] == SZ_W) begin
                                dm_we_q    <= 1'b1;
                                dm_wdata_q <= req_wdata;
                            end
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rsp_rdata_q <= load_data;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (op_q[1:0] == SZ_W) begin
                        dm_we_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        dm_we_q    <= 1'b1;
                        dm_wdata_q <= merged_word;
                        state_q    <= MERGE;
                    end
                end
                MERGE: begin
                    dm_we_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    // A write pending when reset arrives must not land on the reset edge.
    assign dm_write_enable = dm_we_q & ~reset;
    assign dm_addr         = dm_addr_q;
    assign dm_write_data   = dm_wdata_q;

endmodule

// File: tb/tb_dm_load_store_unit.sv
// Scoreboard bench for dm_load_store_unit: byte-array reference model, directed cases then random traffic.
module tb_dm_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dm_write_enable;
    logic [31:0] dm_addr;
    logic [31:0] dm_write_data;
    logic [31:0] dm_read_data;

    always #5 clock = ~clock;

    dm_load_store_unit #(.Data_W(32), .Addr_W(64)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .dm_write_enable (dm_write_enable),
        .dm_addr         (dm_addr),
        .dm_write_data   (dm_write_data),
        .dm_read_data    (dm_read_data)
    );

    // Word-only data memory (64 words), combinational read, aliasing above the index.
    logic [31:0] mem [0:63];
    assign dm_read_data = mem[dm_addr[7:2]];
    always @(posedge clock) if (dm_write_enable) mem[dm_addr[7:2]] <= dm_write_data;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model state: a flat 256-byte little-endian memory.
    logic [7:0] ref_b [0:255];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_accept = 0;
    int   n_drop   = 0;
    int   n_pop    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    function automatic void model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rdata,
                                  output logic err, output int lat);
        int          n;
        logic [31:0] ea;
        logic [31:0] v;
        rdata = 32'h0;
        err   = 1'b0;
        lat   = 0;
        if (op[1:0] == 2'b11) begin
            err = 1'b1;
            return;
        end
        n  = 1 << op[1:0];
        ea = addr & ~(32'(n - 1));
`ifdef LSU_MISALIGN_EN
        if (ea != addr) begin
            err = 1'b1;
            return;
        end
`endif
        if (we) begin
            for (int i = 0; i < n; i++) ref_b[8'(ea + 32'(i))] = 8'(wdata >> (8 * i));
            lat = (n == 4) ? 1 : 2;
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_b[8'(ea + 32'(i))]) << (8 * i));
            if (!op[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            rdata = v;
            lat   = 1;
        end
    endfunction

    // Leaves req_valid high so consecutive calls exercise back-to-back acceptance.
    task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit use_exp = 1'b0,
                         input logic [31:0] exp_rd = 32'h0);
        exp_t e;
        bit   ok = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout: req_ready=0 for 50 cycles, expected 1");
            return;
        end
        @(posedge clock);
        #1;
        model(we, op, addr, wdata, e.rdata, e.err, e.lat);
        if (use_exp) e.rdata = exp_rd;
        e.acc = cyc;
        e.id  = n_accept;
        sb_q.push_back(e);
        n_accept++;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: handshake/idle checks every cycle, scoreboard pop on each response.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            check("req_ready", {31'b0, req_ready}, {31'b0, (n_accept == n_pop + n_drop)});
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_rsp: rsp_valid=1 with no outstanding request, expected 0");
                end else begin
                    e = sb_q.pop_front();
                    $display("rsp #%0d rdata=0x%08h err=%0d lat=%0d", e.id, rsp_rdata, rsp_err, cyc - e.acc);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                    n_pop++;
                end
            end else begin
                check("idle_rsp_zero", rsp_rdata | {31'b0, rsp_err}, 32'h0);
            end
        end
    end

    initial begin
        logic [31:0] w;
        int          wait_k;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_op    = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            w      = $urandom;
            mem[i] = w;
            for (int b = 0; b < 4; b++) ref_b[4*i+b] = w[8*b +: 8];
        end
        repeat (3) @(posedge clock);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        check("rst_dm_we", {31'b0, dm_write_enable}, 32'h0);
        check("rst_dm_addr", dm_addr, 32'h0);
        check("rst_dm_wdata", dm_write_data, 32'h0);
        reset = 1'b0;

        // Reset while an SB sits in MERGE: the write must be dropped.
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b000; req_addr = 32'h24; req_wdata = 32'hA5;
        @(negedge clock);
        @(posedge clock); #1;
        n_accept++;
        req_valid = 1'b0;
        @(posedge clock); #1;
        check("merge_we_before_reset", {31'b0, dm_write_enable}, 32'h1);
        reset = 1'b1;
        #1;
        check("merge_we_gated", {31'b0, dm_write_enable}, 32'h0);
        @(posedge clock); #1;
        n_drop++;
        reset = 1'b0;
        check("post_rst_ready", {31'b0, req_ready}, 32'h1);
        check("post_rst_no_rsp", {31'b0, rsp_valid}, 32'h0);
        check("post_rst_mem_unchanged", mem[9], ref_word(9));

        // Word store/load, then sub-word loads and read-modify-write stores.
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 32'hFFFFFFDE);
        issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 32'h000000DE);
        issue(1'b0, 3'b001, 32'h10, 32'h0, 1'b1, 32'hFFFFBEEF);
        issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b1, 32'h0000DEAD);
        issue(1'b1, 3'b000, 32'h11, 32'h55);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEAD55EF);
        issue(1'b1, 3'b001, 32'h12, 32'h1234);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h123455EF);

        // Misaligned word load, illegal sizes (no write), and address aliasing.
        issue(1'b0, 3'b010, 32'h0E, 32'h0);
        issue(1'b0, 3'b011, 32'h10, 32'h0);
        issue(1'b1, 3'b111, 32'h10, 32'hFFFFFFFF);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h123455EF);
        issue(1'b1, 3'b010, 32'h110, 32'hCAFEF00D);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hCAFEF00D);
        idle(2);

        for (int t = 0; t < 300; t++) begin
            issue(1'($urandom), 3'($urandom), $urandom, $urandom);
            if ($urandom_range(3) == 0) idle($urandom_range(3));
        end
        idle(0);

        wait_k = 0;
        while (sb_q.size() != 0 && wait_k < 50) begin
            @(posedge clock);
            wait_k++;
        end
        #1;
        check("drain_outstanding", 32'(sb_q.size()), 32'h0);
        for (int i = 0; i < 64; i++) check($sformatf("mem_word_%0d", i), mem[i], ref_word(i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
